// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the RV32I fetch controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int              XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2,
        REDIR_WAIT = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_TRAP = 2'd1,
        SRC_JMP  = 2'd2,
        SRC_BR   = 2'd3
    } redir_src_t;

endpackage

`default_nettype wire

// File: rtl/redirect_arb.sv
// ============================================================================
// Module   : redirect_arb
// Brief    : Trap > jump > branch redirect select, target alignment, and the
//            pending-target register. Macro MISALIGN_TRAP_EN selects alignment.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module redirect_arb
    import fetch_pkg::*;
`ifdef MISALIGN_TRAP_EN
#(
    parameter logic [XLEN-1:0] MISALIGN_VEC = 32'h0000_0004
)
`endif
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            pend_load,
    output logic            redir,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pending,
    output logic            misalign
);

    redir_src_t      w_src;
    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] r_pending;

    always_comb begin
        w_src = SRC_NONE;
        if (trap_valid)     w_src = SRC_TRAP;
        else if (jmp_valid) w_src = SRC_JMP;
        else if (br_taken)  w_src = SRC_BR;
    end

    always_comb begin
        w_raw = '0;
        case (w_src)
            SRC_TRAP: w_raw = trap_vec;
            SRC_JMP:  w_raw = jmp_target;
            SRC_BR:   w_raw = br_target;
            default:  w_raw = '0;
        endcase
    end

    assign redir = (w_src != SRC_NONE);

`ifdef MISALIGN_TRAP_EN
    logic w_unaligned;
    logic r_misalign;

    assign w_unaligned = |(w_raw & (PC_STEP - 32'd1));
    assign target      = w_unaligned ? MISALIGN_VEC : w_raw;

    always_ff @(posedge CLK) begin
        if (RST) r_misalign <= 1'b0;
        else     r_misalign <= redir & w_unaligned;
    end

    assign misalign = r_misalign;
`else
    // Without the trap option, low bits are simply cleared.
    assign target   = w_raw & ~(PC_STEP - 32'd1);
    assign misalign = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)            r_pending <= '0;
        else if (pend_load) r_pending <= target;
    end

    assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : PC sequencing and imem req/ack fetch controller with stall buffer
//            and timeout retry. Macro MISALIGN_TRAP_EN enables misalign trap.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] MISALIGN_VEC = 32'h0000_0004
`endif
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] pc_cur,
    output logic            pc_write,
    output logic [XLEN-1:0] pc_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            jmp_valid,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_err,
    output logic            misalign
);

    localparam int                c_tmo_w    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [c_tmo_w-1:0] r_tmo;
    logic             w_tmo_hit;
    logic             w_deliver;
    logic             w_deliver_buf;
    logic             w_buf_load;
    logic             w_err;
    logic             w_pend_load;
    logic             w_redir;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pending;
    logic [XLEN-1:0]  r_buf;
    logic [XLEN-1:0]  r_buf_pc;
    logic             r_instr_valid;
    logic [XLEN-1:0]  r_instr;
    logic [XLEN-1:0]  r_instr_pc;
    logic             r_fetch_err;

    redirect_arb
`ifdef MISALIGN_TRAP_EN
    #(.MISALIGN_VEC(MISALIGN_VEC))
`endif
    u_arb (
        .CLK        (CLK),
        .RST        (RST),
        .trap_valid (trap_valid),
        .trap_vec   (trap_vec),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pend_load  (w_pend_load),
        .redir      (w_redir),
        .target     (w_target),
        .pending    (w_pending),
        .misalign   (misalign)
    );

    assign w_tmo_hit = (r_tmo == c_tmo_last);

    always_comb begin
        w_state_nxt   = r_state;
        pc_write      = 1'b1;
        pc_addr       = pc_cur;
        imem_req      = 1'b0;
        imem_addr     = pc_cur;
        w_pend_load   = 1'b0;
        w_deliver     = 1'b0;
        w_deliver_buf = 1'b0;
        w_buf_load    = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (w_redir) pc_addr = w_target;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (w_redir) begin
                        pc_addr = w_target;
                    end else if (stall) begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_deliver = 1'b1;
                        pc_write  = 1'b0;
                    end
                end else if (w_tmo_hit) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                    if (w_redir) pc_addr = w_target;
                end else if (w_redir) begin
                    // Address must stay put until imem answers the open request.
                    w_pend_load = 1'b1;
                    w_state_nxt = REDIR_WAIT;
                end
            end
            HOLD: begin
                if (w_redir) begin
                    pc_addr     = w_target;
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_deliver_buf = 1'b1;
                    pc_write      = 1'b0;
                    w_state_nxt   = FETCH;
                end
            end
            REDIR_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack || w_tmo_hit) begin
                    pc_addr     = w_redir ? w_target : w_pending;
                    w_state_nxt = imem_ack ? FETCH : IDLE;
                    w_err       = !imem_ack;
                end else if (w_redir) begin
                    w_pend_load = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (RST) begin
            pc_write = 1'b0;
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Any state change clears the count, which covers entry to FETCH/REDIR_WAIT.
    always_ff @(posedge CLK) begin
        if (RST || imem_ack || !imem_req || (w_state_nxt != r_state))
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + c_tmo_w'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_fetch_err   <= 1'b0;
            r_buf         <= '0;
            r_buf_pc      <= '0;
        end else begin
            r_instr_valid <= w_deliver | w_deliver_buf;
            r_fetch_err   <= w_err;
            if (w_deliver) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= pc_cur;
            end else if (w_deliver_buf) begin
                r_instr    <= r_buf;
                r_instr_pc <= r_buf_pc;
            end
            if (w_buf_load) begin
                r_buf    <= imem_rdata;
                r_buf_pc <= pc_cur;
            end
        end
    end

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_err   = r_fetch_err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl (TIMEOUT_CYC=4); honours MISALIGN_TRAP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] pc_cur;
    logic        pc_write;
    logic [31:0] pc_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;
    logic        misalign;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic ack_en;

`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] EXP_MIS_PC  = 32'h0000_0004;
    localparam logic        EXP_MIS_FLG = 1'b1;
`else
    localparam logic [31:0] EXP_MIS_PC  = 32'h0000_0020;
    localparam logic        EXP_MIS_FLG = 1'b0;
`endif

    fetch_ctrl #(.TIMEOUT_CYC(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pc_cur      (pc_cur),
        .pc_write    (pc_write),
        .pc_addr     (pc_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .trap_valid  (trap_valid),
        .trap_vec    (trap_vec),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_err   (fetch_err),
        .misalign    (misalign)
    );

    always #5 CLK = ~CLK;

    // PC register that the controller steers.
    always @(posedge CLK) begin
        if (RST)           pc_cur <= 32'h0;
        else if (pc_write) pc_cur <= pc_addr;
        else               pc_cur <= pc_cur + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] a);
        exp_q.push_back({mem_word(a), a});
    endtask

    task automatic cyc_begin();
        #1;
        imem_ack   = ack_en & imem_req;
        imem_rdata = mem_word(imem_addr);
        #1;
    endtask

    task automatic cyc_end();
        @(posedge CLK);
        #1;
        imem_ack   = 1'b0;
        trap_valid = 1'b0;
        jmp_valid  = 1'b0;
        br_taken   = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST && instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr_valid: got instr_pc %h, required no instr_valid", instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_instr", instr, mon_e.word);
                chk("sb_instr_pc", instr_pc, mon_e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; ack_en = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        trap_valid = 1'b0; trap_vec = '0; jmp_valid = 1'b0; jmp_target = '0;
        br_taken = 1'b0; br_target = '0;
        @(posedge CLK);
        do_reset();

        // Sequential fetch from reset: 0,4,8,C.
        ack_en = 1'b1;
        cyc_begin(); chk("idle_req", {31'd0, imem_req}, 32'd0); cyc_end();
        for (int i = 0; i < 4; i++) begin
            cyc_begin();
            chk("seq_addr", imem_addr, 32'(i * 4));
            expect_instr(32'(i * 4));
            cyc_end();
        end
        ack_en = 1'b0;
        cyc_begin(); cyc_end();

        // Reset while a request is open, then a stray ack in IDLE.
        do_reset();
        cyc_begin();
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);
        chk("late_ack_pc_addr", pc_addr, 32'h0);
        cyc_end();

        // Stall: ack at 8 with stall high three cycles.
        ack_en = 1'b1;
        cyc_begin(); chk("late_ack_no_valid", {31'd0, instr_valid}, 32'd0); expect_instr(32'h0); cyc_end();
        cyc_begin(); expect_instr(32'h4); cyc_end();
        stall = 1'b1;
        cyc_begin();
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_pc_write", {31'd0, pc_write}, 32'd1);
        chk("stall_pc_addr", pc_addr, 32'h8);
        cyc_end();
        for (int i = 0; i < 2; i++) begin
            cyc_begin();
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_no_valid", {31'd0, instr_valid}, 32'd0);
            chk("hold_pc", pc_cur, 32'h8);
            cyc_end();
        end
        stall = 1'b0;
        cyc_begin();
        chk("unstall_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("unstall_pc_write", {31'd0, pc_write}, 32'd0);
        expect_instr(32'h8);
        cyc_end();

        // Timeout at 0xC with no ack.
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc_begin();
            chk("tmo_req", {31'd0, imem_req}, 32'd1);
            chk("tmo_addr", imem_addr, 32'hC);
            chk("tmo_no_err", {31'd0, fetch_err}, 32'd0);
            cyc_end();
        end
        cyc_begin();
        chk("tmo_err", {31'd0, fetch_err}, 32'd1);
        chk("tmo_req_drop", {31'd0, imem_req}, 32'd0);
        cyc_end();
        ack_en = 1'b1;
        cyc_begin();
        chk("retry_req", {31'd0, imem_req}, 32'd1);
        chk("retry_addr", imem_addr, 32'hC);
        chk("retry_err_clear", {31'd0, fetch_err}, 32'd0);
        expect_instr(32'hC);
        cyc_end();

        // Late branch redirect while 0x10 is outstanding.
        ack_en = 1'b0; br_taken = 1'b1; br_target = 32'h40;
        cyc_begin();
        chk("lr_addr", imem_addr, 32'h10);
        chk("lr_pc_addr_hold", pc_addr, 32'h10);
        cyc_end();
        cyc_begin();
        chk("lr_wait_req", {31'd0, imem_req}, 32'd1);
        chk("lr_wait_addr", imem_addr, 32'h10);
        cyc_end();
        ack_en = 1'b1;
        cyc_begin();
        chk("lr_pc_addr", pc_addr, 32'h40);
        chk("lr_pc_write", {31'd0, pc_write}, 32'd1);
        cyc_end();

        // Priority: trap over jump over branch.
        trap_valid = 1'b1; trap_vec = 32'h100;
        jmp_valid = 1'b1; jmp_target = 32'h200;
        br_taken = 1'b1; br_target = 32'h300;
        cyc_begin();
        chk("lr_next_addr", imem_addr, 32'h40);
        chk("prio_trap", pc_addr, 32'h100);
        cyc_end();
        jmp_valid = 1'b1; jmp_target = 32'h200;
        br_taken = 1'b1; br_target = 32'h300;
        cyc_begin();
        chk("trap_addr", imem_addr, 32'h100);
        chk("prio_jmp", pc_addr, 32'h200);
        cyc_end();
        cyc_begin();
        chk("jmp_addr", imem_addr, 32'h200);
        expect_instr(32'h200);
        cyc_end();

        // Misaligned jump target.
        jmp_valid = 1'b1; jmp_target = 32'h22;
        cyc_begin();
        chk("mis_pc_addr", pc_addr, EXP_MIS_PC);
        chk("mis_before", {31'd0, misalign}, 32'd0);
        cyc_end();
        ack_en = 1'b0;
        cyc_begin();
        chk("mis_flag", {31'd0, misalign}, {31'd0, EXP_MIS_FLG});
        chk("mis_addr", imem_addr, EXP_MIS_PC);
        cyc_end();
        cyc_begin(); chk("mis_pulse_end", {31'd0, misalign}, 32'd0); cyc_end();
        cyc_begin(); cyc_end();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
